// File: rtl/banco_regs_pipe_if.sv
// Instruction-in / operand-out handshake and write-back bus of the register bank.
interface banco_regs_pipe_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 32
);
    logic               instr_valid;
    logic [INSTR_W-1:0] instruccion;
    logic               instr_ready;
    logic               op_valid;
    logic               op_ready;
    logic [DATA_W-1:0]  rs_data;
    logic [DATA_W-1:0]  rt_data;
    logic [ADDR_W-1:0]  rd_addr;
    logic               wb_en;
    logic [ADDR_W-1:0]  wb_addr;
    logic [DATA_W-1:0]  wb_data;

    modport master (
        output instr_valid, instruccion, op_ready, wb_en, wb_addr, wb_data,
        input  instr_ready, op_valid, rs_data, rt_data, rd_addr
    );

    modport slave (
        input  instr_valid, instruccion, op_ready, wb_en, wb_addr, wb_data,
        output instr_ready, op_valid, rs_data, rt_data, rd_addr
    );
endinterface

// File: rtl/banco_regs_pipe.sv
// Register bank with rs/rt decode, one registered operand stage (valid/ready),
// write-back bypass on read and coherent update of operands held in a stall.
module banco_regs_pipe #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int INSTR_W  = 32,
    parameter int RS_LSB   = 21,
    parameter int RT_LSB   = 16,
    parameter int RD_LSB   = 11,
    parameter int ZERO_REG = 1
) (
    input logic               clk,
    input logic               rst_n,
    banco_regs_pipe_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    if (RS_LSB + ADDR_W > INSTR_W || RT_LSB + ADDR_W > INSTR_W ||
        RD_LSB + ADDR_W > INSTR_W) begin : g_bad_fields
        $error("banco_regs_pipe: instruction field exceeds INSTR_W");
    end

    logic [DATA_W-1:0] rf [DEPTH];
    logic [ADDR_W-1:0] rs, rt, rd;
    logic [ADDR_W-1:0] held_rs, held_rt;
    logic [DATA_W-1:0] rs_rd, rt_rd;
    logic              wb_live;
    logic              accept;

    // With a hardwired r0 the write is dropped, so r0 is never bypassed or stored.
    always_comb begin
        rs      = bus.instruccion[RS_LSB +: ADDR_W];
        rt      = bus.instruccion[RT_LSB +: ADDR_W];
        rd      = bus.instruccion[RD_LSB +: ADDR_W];
        wb_live = bus.wb_en && !(ZERO_REG != 0 && bus.wb_addr == '0);
        rs_rd   = (wb_live && bus.wb_addr == rs) ? bus.wb_data : rf[rs];
        rt_rd   = (wb_live && bus.wb_addr == rt) ? bus.wb_data : rf[rt];
    end

    always_comb begin
        bus.instr_ready = !bus.op_valid || bus.op_ready;
        accept          = bus.instr_valid && bus.instr_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_live) begin
            rf[bus.wb_addr] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.op_valid <= 1'b0;
            bus.rs_data  <= '0;
            bus.rt_data  <= '0;
            bus.rd_addr  <= '0;
            held_rs      <= '0;
            held_rt      <= '0;
        end else if (accept) begin
            bus.op_valid <= 1'b1;
            bus.rs_data  <= rs_rd;
            bus.rt_data  <= rt_rd;
            bus.rd_addr  <= rd;
            held_rs      <= rs;
            held_rt      <= rt;
        end else if (bus.op_valid && bus.op_ready) begin
            bus.op_valid <= 1'b0;
        end else if (bus.op_valid) begin
            // Stalled entry tracks writes to its source registers.
            if (wb_live && bus.wb_addr == held_rs) begin
                bus.rs_data <= bus.wb_data;
            end
            if (wb_live && bus.wb_addr == held_rt) begin
                bus.rt_data <= bus.wb_data;
            end
        end
    end
endmodule
